// File: rtl/mem_arbiter_if.sv
// Request/response bundle between two requesters (core "c_", loader "l_"),
// the arbiter and a single-port data memory.
//   slave  : arbiter side (takes requests and mem_rdata, drives grants, read data, memory controls, busy)
//   master : environment side (drives requests and mem_rdata, observes the rest)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a core and a loader shared access to one
// data memory with a fixed read latency of MEM_LAT cycles (1..3).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_arbiter_if.slave -- requests, grants, read data, memory port, busy
// One access is in flight at a time: IDLE arbitrates, ISSUE drives the
// memory for one cycle, WAIT counts down the read latency. All outputs are
// registered.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_l;    // 1 = loader won the last arbitration
    logic               lat_l;     // latched requester id (1 = loader)
    logic               lat_we;    // latched access direction

    logic               pick_l;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    // Winner select: a lone request wins; on a tie the previous loser wins.
    always_comb begin
        pick_l    = 1'b0;
        win_we    = bus.c_we;
        win_addr  = bus.c_addr;
        win_wdata = bus.c_wdata;
        pick_l    = bus.l_req && (!bus.c_req || !last_l);
        if (pick_l) begin
            win_we    = bus.l_we;
            win_addr  = bus.l_addr;
            win_wdata = bus.l_wdata;
        end
    end

    // Control FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_l        <= 1'b1;
            lat_l         <= 1'b0;
            lat_we        <= 1'b0;
            bus.c_gnt     <= 1'b0;
            bus.l_gnt     <= 1'b0;
            bus.c_rvalid  <= 1'b0;
            bus.l_rvalid  <= 1'b0;
            bus.c_rdata   <= '0;
            bus.l_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.c_gnt    <= 1'b0;
            bus.l_gnt    <= 1'b0;
            bus.c_rvalid <= 1'b0;
            bus.l_rvalid <= 1'b0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.c_req || bus.l_req) begin
                        state         <= ISSUE;
                        last_l        <= pick_l;
                        lat_l         <= pick_l;
                        lat_we        <= win_we;
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= win_we;
                        bus.c_gnt     <= !pick_l;
                        bus.l_gnt     <= pick_l;
                        bus.busy      <= 1'b1;
                    end else begin
                        bus.busy      <= 1'b0;
                    end
                end

                ISSUE: begin
                    if (lat_we) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state    <= WAIT;
                        cnt      <= CNT_W'(MEM_LAT);
                    end
                end

                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // mem_rdata is valid in the cycle the counter reads 1.
                    if (cnt == CNT_W'(1)) begin
                        if (lat_l) begin
                            bus.l_rdata  <= bus.mem_rdata;
                            bus.l_rvalid <= 1'b1;
                        end else begin
                            bus.c_rdata  <= bus.mem_rdata;
                            bus.c_rvalid <= 1'b1;
                        end
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with a
// behavioural memory, checked every cycle against a transaction-level model
// plus directed literal expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]  c_req, c_we, l_req, l_we;
    logic [7:0]  c_addr [2];
    logic [7:0]  l_addr [2];
    logic [15:0] c_wdata [2];
    logic [15:0] l_wdata [2];

    logic [1:0]  c_gnt, l_gnt, c_rv, l_rv, m_en, m_we, busy;
    logic [15:0] c_rdata [2];
    logic [15:0] l_rdata [2];
    logic [7:0]  m_addr [2];
    logic [15:0] m_wdata [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : {a, ~a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();
        logic [15:0] mem [256];
        logic [15:0] rpipe [3];

        assign bus.c_req     = c_req[g];
        assign bus.c_we      = c_we[g];
        assign bus.c_addr    = c_addr[g];
        assign bus.c_wdata   = c_wdata[g];
        assign bus.l_req     = l_req[g];
        assign bus.l_we      = l_we[g];
        assign bus.l_addr    = l_addr[g];
        assign bus.l_wdata   = l_wdata[g];
        assign bus.mem_rdata = rpipe[LAT-1];

        assign c_gnt[g]   = bus.c_gnt;
        assign l_gnt[g]   = bus.l_gnt;
        assign c_rv[g]    = bus.c_rvalid;
        assign l_rv[g]    = bus.l_rvalid;
        assign c_rdata[g] = bus.c_rdata;
        assign l_rdata[g] = bus.l_rdata;
        assign m_en[g]    = bus.mem_en;
        assign m_we[g]    = bus.mem_we;
        assign m_addr[g]  = bus.mem_addr;
        assign m_wdata[g] = bus.mem_wdata;
        assign busy[g]    = bus.busy;

        initial begin
            for (int a = 0; a < 256; a++) mem[a] = init_val(8'(a));
            for (int i = 0; i < 3; i++) rpipe[i] = 16'h0;
        end

        // Environment memory: data of an enabled read appears LAT cycles later.
        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_en) rpipe[0] <= mem[bus.mem_addr];
            rpipe[1] <= rpipe[0];
            rpipe[2] <= rpipe[1];
        end

        mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
            .clock (clk),
            .reset (rst_n),
            .bus   (bus.slave)
        );
    end

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        gc, gl, en, we, rc, rl;
        logic [15:0] data;
    } ev_t;

    ev_t         sched [2][8];   // sched[d][k] = expected pulses k cycles from now
    int          busy_left [2];  // busy cycles still ahead (0 = idle now)
    bit          last_l [2];
    logic [7:0]  e_addr [2];
    logic [15:0] e_wdata [2];
    logic [15:0] e_crd [2];
    logic [15:0] e_lrd [2];
    logic [15:0] mmem [2][256];
    int          lat [2] = '{1, 3};

    initial begin
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) mmem[d][a] = init_val(8'(a));
    end

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) sched[d][i] = '0;
                busy_left[d] = 0;
                last_l[d]    = 1'b1;
                e_addr[d]    = '0;
                e_wdata[d]   = '0;
                e_crd[d]     = '0;
                e_lrd[d]     = '0;
            end else begin
                bit          idle, pl, we;
                logic [7:0]  a;
                logic [15:0] wd;
                idle = (busy_left[d] == 0);
                for (int i = 0; i < 7; i++) sched[d][i] = sched[d][i+1];
                sched[d][7] = '0;
                if (busy_left[d] > 0) busy_left[d]--;
                if (idle && (c_req[d] || l_req[d])) begin
                    pl = l_req[d] && (!c_req[d] || !last_l[d]);
                    last_l[d] = pl;
                    we = pl ? l_we[d]    : c_we[d];
                    a  = pl ? l_addr[d]  : c_addr[d];
                    wd = pl ? l_wdata[d] : c_wdata[d];
                    sched[d][0].gc = !pl;
                    sched[d][0].gl = pl;
                    sched[d][0].en = 1'b1;
                    sched[d][0].we = we;
                    e_addr[d]  = a;
                    e_wdata[d] = wd;
                    if (we) begin
                        mmem[d][a]   = wd;
                        busy_left[d] = 1;
                    end else begin
                        busy_left[d] = 1 + lat[d];
                        sched[d][1+lat[d]].rc   = !pl;
                        sched[d][1+lat[d]].rl   = pl;
                        sched[d][1+lat[d]].data = mmem[d][a];
                    end
                end
                if (sched[d][0].rc) e_crd[d] = sched[d][0].data;
                if (sched[d][0].rl) e_lrd[d] = sched[d][0].data;
            end
        end
    end

    // ---------------- checking ----------------
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void cmp_model();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("m%0d.c_gnt", d),     32'(c_gnt[d]),   32'(sched[d][0].gc));
            chk($sformatf("m%0d.l_gnt", d),     32'(l_gnt[d]),   32'(sched[d][0].gl));
            chk($sformatf("m%0d.mem_en", d),    32'(m_en[d]),    32'(sched[d][0].en));
            chk($sformatf("m%0d.mem_we", d),    32'(m_we[d]),    32'(sched[d][0].we));
            chk($sformatf("m%0d.c_rvalid", d),  32'(c_rv[d]),    32'(sched[d][0].rc));
            chk($sformatf("m%0d.l_rvalid", d),  32'(l_rv[d]),    32'(sched[d][0].rl));
            chk($sformatf("m%0d.busy", d),      32'(busy[d]),    32'(busy_left[d] > 0));
            chk($sformatf("m%0d.mem_addr", d),  32'(m_addr[d]),  32'(e_addr[d]));
            chk($sformatf("m%0d.mem_wdata", d), 32'(m_wdata[d]), 32'(e_wdata[d]));
            chk($sformatf("m%0d.c_rdata", d),   32'(c_rdata[d]), 32'(e_crd[d]));
            chk($sformatf("m%0d.l_rdata", d),   32'(l_rdata[d]), 32'(e_lrd[d]));
        end
    endfunction

    // Advance one cycle; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        cmp_model();
    endtask

    task automatic both_req(input int d,
                            input bit c_on, input bit cw, input logic [7:0] ca, input logic [15:0] cd,
                            input bit l_on, input bit lw, input logic [7:0] la, input logic [15:0] ld);
        c_req[d] = c_on; c_we[d] = cw; c_addr[d] = ca; c_wdata[d] = cd;
        l_req[d] = l_on; l_we[d] = lw; l_addr[d] = la; l_wdata[d] = ld;
        for (int i = 0; i < 20 && (c_req[d] || l_req[d]); i++) begin
            step();
            if (c_gnt[d]) c_req[d] = 1'b0;
            if (l_gnt[d]) l_req[d] = 1'b0;
        end
        chk("grant_timeout", 32'({c_req[d], l_req[d]}), 32'h0);
        c_req[d] = 1'b0;
        l_req[d] = 1'b0;
        for (int i = 0; i < 10 && busy[d]; i++) step();
        chk("idle_timeout", 32'(busy[d]), 32'h0);
    endtask

    initial begin
        int bcnt, rvc, gcyc;
        rst_n = 1'b0;
        c_req = '0; l_req = '0; c_we = '0; l_we = '0;
        for (int d = 0; d < 2; d++) begin
            c_addr[d] = '0; l_addr[d] = '0; c_wdata[d] = '0; l_wdata[d] = '0;
        end
        step(); step();
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.mem_addr", 32'(m_addr[0]), 32'h0);
        chk("rst.c_rdata", 32'(c_rdata[1]), 32'h0);
        rst_n = 1'b1;
        step();

        // Core write 0x05 <- 0xBEEF on the MEM_LAT=1 instance.
        c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 8'h05; c_wdata[0] = 16'hBEEF;
        step();
        chk("wr.c_gnt", 32'(c_gnt[0]), 32'h1);
        chk("wr.mem_en_we", 32'({m_en[0], m_we[0]}), 32'h3);
        chk("wr.mem_addr", 32'(m_addr[0]), 32'h05);
        chk("wr.mem_wdata", 32'(m_wdata[0]), 32'hBEEF);
        c_req[0] = 1'b0;
        step();
        chk("wr.no_rvalid", 32'({c_gnt[0], c_rv[0], busy[0]}), 32'h0);

        // Core read 0x05 -> gnt at N+1, rvalid at N+3.
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 8'h05;
        step();
        chk("rd.c_gnt", 32'(c_gnt[0]), 32'h1);
        c_req[0] = 1'b0;
        step();
        chk("rd.early_rvalid", 32'(c_rv[0]), 32'h0);
        step();
        chk("rd.c_rvalid", 32'(c_rv[0]), 32'h1);
        chk("rd.c_rdata", 32'(c_rdata[0]), 32'hBEEF);
        chk("rd.l_rdata", 32'(l_rdata[0]), 32'h0);

        // Both requesting writes continuously from reset: c, l, c, l every 2 cycles.
        c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 8'h20; c_wdata[0] = 16'h1111;
        l_req[0] = 1'b1; l_we[0] = 1'b1; l_addr[0] = 8'h30; l_wdata[0] = 16'h2222;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("rr.c_gnt%0d", i), 32'(c_gnt[0]), 32'(i % 4 == 0));
            chk($sformatf("rr.l_gnt%0d", i), 32'(l_gnt[0]), 32'(i % 4 == 2));
        end
        c_req[0] = 1'b0; l_req[0] = 1'b0;
        step(); step();

        // Loader read 0x10 on the MEM_LAT=3 instance: 4 busy cycles, rvalid at N+5.
        l_req[1] = 1'b1; l_we[1] = 1'b0; l_addr[1] = 8'h10;
        bcnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) begin
                chk("lat3.l_gnt", 32'(l_gnt[1]), 32'h1);
                l_req[1] = 1'b0;
            end
            bcnt += int'(busy[1]);
            if (i == 5) begin
                chk("lat3.l_rvalid", 32'(l_rv[1]), 32'h1);
                chk("lat3.l_rdata", 32'(l_rdata[1]), 32'h1234);
            end
        end
        chk("lat3.busy_cycles", 32'(bcnt), 32'd4);

        // Reset during WAIT abandons the read.
        c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 8'h10;
        step();
        chk("rstw.c_gnt", 32'(c_gnt[1]), 32'h1);
        c_req[1] = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rstw.busy", 32'(busy[1]), 32'h0);
        chk("rstw.mem_addr", 32'(m_addr[1]), 32'h0);
        chk("rstw.c_rdata", 32'(c_rdata[1]), 32'h0);
        step(); step();
        rst_n = 1'b1;
        rvc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            rvc += int'(c_rv[1]) + int'(c_gnt[1]);
        end
        chk("rstw.no_late_pulse", 32'(rvc), 32'h0);
        c_req[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 8'h44; c_wdata[1] = 16'h4444;
        step();
        chk("rstw.next_gnt", 32'(c_gnt[1]), 32'h1);
        chk("rstw.next_addr", 32'(m_addr[1]), 32'h44);
        c_req[1] = 1'b0;
        step();

        // Core request arriving while a loader read waits.
        l_req[1] = 1'b1; l_we[1] = 1'b0; l_addr[1] = 8'h11;
        gcyc = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (l_gnt[1]) l_req[1] = 1'b0;
            if (c_gnt[1]) begin
                gcyc = i;
                c_req[1] = 1'b0;
            end
            if (i == 2) begin
                c_req[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 8'h50; c_wdata[1] = 16'h5555;
            end
            if (i == 5) begin
                chk("wait.l_rvalid", 32'(l_rv[1]), 32'h1);
                chk("wait.l_rdata", 32'(l_rdata[1]), 32'h11EE);
            end
        end
        chk("wait.c_gnt_cycle", 32'(gcyc), 32'd6);
        c_req[1] = 1'b0; l_req[1] = 1'b0;
        step();

        // Mixed traffic on both instances, checked by the model every cycle.
        for (int d = 0; d < 2; d++) begin
            both_req(d, 1, 1, 8'h60, 16'h6060, 1, 1, 8'h61, 16'h6161);
            both_req(d, 1, 0, 8'h61, 16'h0000, 1, 0, 8'h60, 16'h0000);
            both_req(d, 1, 0, 8'h05, 16'h0000, 1, 1, 8'h05, 16'h0F0F);
            both_req(d, 1, 1, 8'h62, 16'hC0DE, 1, 0, 8'h62, 16'h0000);
            both_req(d, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h05, 16'h0000);
            both_req(d, 1, 0, 8'h62, 16'h0000, 0, 0, 8'h00, 16'h0000);
        end
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, memory address width; DATA_W, default 16, data width; MEM_LAT, default 1, data-memory read latency in cycles, legal range 1..3.
REQ-002 Port clock  in  1  single clock; all flops rising-edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Ports c_req/l_req  in  1  core/loader access request; held high until the matching gnt.
REQ-005 Ports c_we/l_we  in  1  1 = write, 0 = read; stable while req is high.
REQ-006 Ports c_addr/l_addr  in  ADDR_W  access address; stable while req is high.
REQ-007 Ports c_wdata/l_wdata  in  DATA_W  write data; stable while req is high.
REQ-008 Ports c_gnt/l_gnt  out  1  one-cycle pulse marking the cycle the request is issued to memory.
REQ-009 Ports c_rvalid/l_rvalid  out  1  one-cycle pulse marking that read data is valid.
REQ-010 Ports c_rdata/l_rdata  out  DATA_W  registered read data; holds until the requester's next read completes.
REQ-011 Ports mem_en, mem_we  out  1  memory enable and write strobe.
REQ-012 Ports mem_addr, mem_wdata  out  ADDR_W, DATA_W  memory address and write data.
REQ-013 Port mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-014 Port busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE and WAIT, all registered.
REQ-016 IDLE: if no req is high, stay in IDLE; otherwise pick the winner, latch its we/addr/wdata and requester id, and go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: if only one req is high, it wins; if both are high, the requester that did not win last wins.
REQ-018 The last-winner pointer SHALL update only on entry to ISSUE.
REQ-019 ISSUE lasts exactly 1 cycle: mem_en=1, mem_we/mem_addr/mem_wdata from the latched request, and the winner's gnt=1.
REQ-020 ISSUE next state: IDLE if the latched request is a write; WAIT with latency counter = MEM_LAT if it is a read.
REQ-021 WAIT: decrement the counter each cycle.
REQ-022 On the WAIT cycle where the counter reaches 1, capture mem_rdata into the winner's rdata register, pulse its rvalid in the following cycle, and go to IDLE.
REQ-023 Latency: a write is req seen in IDLE (cycle N) -> gnt at N+1. A read is gnt at N+1 -> rvalid at N+2+MEM_LAT.
REQ-024 Minimum spacing between accesses SHALL be 2 cycles for writes and MEM_LAT+2 cycles for reads.
REQ-025 Outside ISSUE, mem_en, mem_we, both gnt and both rvalid SHALL be 0; mem_addr/mem_wdata hold their last values.
REQ-026 A request arriving while busy SHALL wait and be arbitrated in the next IDLE cycle.
REQ-027 Once a request is latched, dropping its req SHALL NOT cancel the access.
REQ-028 The loser of a tie SHALL keep req asserted and SHALL win the next arbitration if it is still requesting.
REQ-029 The rvalid pulse and the IDLE arbitration in the same cycle SHALL both proceed; rdata of the other requester is unaffected.
REQ-030 Address/data values SHALL pass unmodified; no range checks.

Reset
REQ-031 While reset=0, asynchronously: state=IDLE, counter=0, all gnt/rvalid/mem_en/mem_we/busy=0, mem_addr/mem_wdata/c_rdata/l_rdata=0.
REQ-032 While reset=0, the last-winner pointer SHALL be set to loader, so the core wins the first tie.
REQ-033 Reset asserted mid-access SHALL abandon the access with no gnt/rvalid issued afterwards.
REQ-034 After reset=1, the first arbitration SHALL occur on the first rising edge with a req high.

Verification
REQ-035 MEM_LAT=1; core write addr 0x05 data 0xBEEF -> c_gnt and mem_en/mem_we=1 with mem_addr=0x05, mem_wdata=0xBEEF 1 cycle after req; no c_rvalid.
REQ-036 Core read addr 0x05, memory model returns 0xBEEF -> c_gnt at N+1, c_rvalid at N+3 with c_rdata=0xBEEF; l_rdata stays 0.
REQ-037 Both req high with writes continuously from reset -> grants alternate core, loader, core, loader, spaced 2 cycles apart.
REQ-038 MEM_LAT=3; loader read 0x10 returning 0x1234 -> busy high for 4 cycles, l_rvalid at N+5 with l_rdata=0x1234.
REQ-039 reset driven low during WAIT of a read -> outputs zero immediately; no rvalid after release; next core write is granted normally.
REQ-040 Core req raised while a loader read is in WAIT -> core granted on the cycle after loader returns to IDLE; loader read data is correct.
